// File: rtl/ov5640_init_sequencer.sv
// OV5640 init sequencer: walks a 24-bit {addr,data} table ROM and issues each entry as an SCCB write.
// Supports two table regions, delay/end markers, automatic wait after a soft reset write, and NACK retry.
//   state    | meaning
//   S_IDLE   | waiting for start after reset
//   S_FETCH  | table address presented to ROM
//   S_LATCH  | ROM word arrives, captured into r_word
//   S_DECODE | classify word: write, delay marker or end marker
//   S_WRITE  | wr_req held until wr_done; NACK retries stay here
//   S_DELAY  | millisecond wait (marker or post soft-reset)
//   S_DONE   | sequence finished, outputs hold until next start
module ov5640_init_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int MODE0_BASE     = 0,
  parameter int MODE0_LEN      = 250,
  parameter int MODE1_BASE     = 0,
  parameter int MODE1_LEN      = 250,
  parameter int CLK_FREQ       = 50_000_000,
  parameter int RESET_DELAY_MS = 5,
  parameter int MAX_RETRY      = 3
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_mode,
  output logic [ADDR_WIDTH-1:0] o_tbl_addr,
  input  logic [23:0]           i_tbl_q,
  output logic                  o_wr_req,
  output logic [15:0]           o_wr_addr,
  output logic [7:0]            o_wr_data,
  input  logic                  i_wr_done,
  input  logic                  i_wr_nack,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [ADDR_WIDTH-1:0] o_entry_cnt
);

  localparam int TICK = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;
  localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int CW   = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]         PRESC_LOAD = PW'(TICK - 1);
  localparam logic [CW-1:0]         LEN0       = CW'(MODE0_LEN);
  localparam logic [CW-1:0]         LEN1       = CW'(MODE1_LEN);
  localparam logic [ADDR_WIDTH-1:0] BASE0      = ADDR_WIDTH'(MODE0_BASE);
  localparam logic [ADDR_WIDTH-1:0] BASE1      = ADDR_WIDTH'(MODE1_BASE);
  localparam logic [7:0]            RST_MS     = 8'(RESET_DELAY_MS);
  localparam logic [7:0]            RETRY_MAX  = 8'(MAX_RETRY);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_WRITE, S_DELAY, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_tbl_addr, r_entry_cnt;
  logic [23:0]           r_word;
  logic                  r_wr_req, r_err;
  logic [15:0]           r_wr_addr;
  logic [7:0]            r_wr_data, r_retry_cnt, r_ms_left;
  logic [PW-1:0]         r_presc;

  logic          w_start_ok, w_advance, w_end, w_load_write, w_load_delay, w_retry, w_abort;
  logic [7:0]    w_delay_ms;
  logic [CW-1:0] w_cnt_inc;
  logic          w_last, w_ack, w_nack, w_rst_write;

  assign w_cnt_inc   = {1'b0, r_entry_cnt} + 1'b1;
  assign w_last      = (w_cnt_inc == (r_mode ? LEN1 : LEN0));
  assign w_ack       = (r_state == S_WRITE) & r_wr_req & i_wr_done & ~i_wr_nack;
  assign w_nack      = (r_state == S_WRITE) & r_wr_req & i_wr_done & i_wr_nack;
  assign w_rst_write = (r_wr_addr == 16'h3008) & r_wr_data[7] & (RST_MS != 8'd0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_ok   = 1'b0;
    w_advance    = 1'b0;
    w_end        = 1'b0;
    w_load_write = 1'b0;
    w_load_delay = 1'b0;
    w_delay_ms   = 8'd0;
    w_retry      = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) begin
        w_start_ok  = 1'b1;
        w_state_nxt = S_FETCH;
      end
      S_FETCH: w_state_nxt = S_LATCH;
      S_LATCH: w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (r_word[23:8] == 16'hFFFE) begin
          w_end       = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_word[23:8] == 16'hFFFF) begin
          if (r_word[7:0] == 8'd0) begin
            w_advance = 1'b1;
          end else begin
            w_load_delay = 1'b1;
            w_delay_ms   = r_word[7:0];
            w_state_nxt  = S_DELAY;
          end
        end else begin
          w_load_write = 1'b1;
          w_state_nxt  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_ack) begin
          if (w_rst_write) begin
            w_load_delay = 1'b1;
            w_delay_ms   = RST_MS;
            w_state_nxt  = S_DELAY;
          end else begin
            w_advance = 1'b1;
          end
        end else if (w_nack) begin
          if (r_retry_cnt < RETRY_MAX) begin
            w_retry = 1'b1;
          end else begin
            w_abort     = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DELAY: if (r_presc == '0 && r_ms_left == 8'd1) w_advance = 1'b1;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_advance) w_state_nxt = w_last ? S_DONE : S_FETCH;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode      <= 1'b0;
      r_tbl_addr  <= '0;
      r_entry_cnt <= '0;
      r_word      <= 24'd0;
      r_wr_req    <= 1'b0;
      r_wr_addr   <= 16'd0;
      r_wr_data   <= 8'd0;
      r_err       <= 1'b0;
      r_retry_cnt <= 8'd0;
      r_ms_left   <= 8'd0;
      r_presc     <= '0;
    end else begin
      if (w_start_ok) begin
        r_mode      <= i_mode;
        r_tbl_addr  <= i_mode ? BASE1 : BASE0;
        r_entry_cnt <= '0;
        r_err       <= 1'b0;
        r_retry_cnt <= 8'd0;
      end
      if (r_state == S_LATCH) r_word <= i_tbl_q;
      // A NACKed request is dropped for one clock, then re-raised with the same address/data.
      if (w_load_write) begin
        r_wr_addr <= r_word[23:8];
        r_wr_data <= r_word[7:0];
        r_wr_req  <= 1'b1;
      end else if (w_ack || w_nack) begin
        r_wr_req <= 1'b0;
      end else if (r_state == S_WRITE && !r_wr_req) begin
        r_wr_req <= 1'b1;
      end
      if (w_retry) r_retry_cnt <= r_retry_cnt + 8'd1;
      if (w_abort) r_err <= 1'b1;
      if (w_load_delay) begin
        r_presc   <= PRESC_LOAD;
        r_ms_left <= w_delay_ms;
      end else if (r_state == S_DELAY) begin
        if (r_presc == '0) begin
          r_presc   <= PRESC_LOAD;
          r_ms_left <= r_ms_left - 8'd1;
        end else begin
          r_presc <= r_presc - 1'b1;
        end
      end
      if (w_advance || w_end) begin
        r_entry_cnt <= w_cnt_inc[ADDR_WIDTH-1:0];
        r_retry_cnt <= 8'd0;
        if (w_advance && !w_last) r_tbl_addr <= r_tbl_addr + 1'b1;
      end
    end
  end

  assign o_tbl_addr  = r_tbl_addr;
  assign o_wr_req    = r_wr_req;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_err       = r_err;
  assign o_entry_cnt = r_entry_cnt;
  assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Bench for ov5640_init_sequencer: ROM + SCCB responder models, and a table-walking reference
// that predicts the request stream, err and entry count for each run.
module tb_ov5640_init_sequencer;
  localparam int M0_BASE = 0,   M0_LEN = 250;
  localparam int M1_BASE = 200, M1_LEN = 10;
  localparam int CLK_FREQ = 10_000, TICK = CLK_FREQ / 1000;
  localparam int RST_MS = 5, MAX_RETRY = 3, LAT = 20;

  logic clk = 0, reset = 1, start = 0, mode = 0;
  logic [7:0]  tbl_addr, entry_cnt;
  logic [23:0] tbl_q = 0;
  logic wr_req, wr_done = 0, wr_nack = 0, busy, done, err;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int checks = 0, errors = 0, cyc = 0;

  ov5640_init_sequencer #(
    .ADDR_WIDTH(8), .MODE0_BASE(M0_BASE), .MODE0_LEN(M0_LEN), .MODE1_BASE(M1_BASE), .MODE1_LEN(M1_LEN),
    .CLK_FREQ(CLK_FREQ), .RESET_DELAY_MS(RST_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .o_tbl_addr(tbl_addr), .i_tbl_q(tbl_q),
    .o_wr_req(wr_req), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .i_wr_done(wr_done), .i_wr_nack(wr_nack),
    .o_busy(busy), .o_done(done), .o_err(err), .o_entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] rom [0:255];
  always @(posedge clk) tbl_q <= rom[tbl_addr];

  // SCCB responder: every rising wr_req is one request, answered LAT clocks later.
  logic [23:0] log_q[$];
  int          rise_cyc[$], done_cyc[$];
  bit          resp_q[$];
  bit          pending = 0, prev_req = 0;
  int          lat_cnt = 0;
  logic [23:0] cur_req = 0;
  int          addr_min = 1000, addr_max = -1;

  always @(negedge clk) begin
    wr_done = 0;
    wr_nack = 0;
    if (reset) begin
      pending  = 0;
      prev_req = 0;
    end else begin
      if (busy) begin
        if (int'(tbl_addr) < addr_min) addr_min = int'(tbl_addr);
        if (int'(tbl_addr) > addr_max) addr_max = int'(tbl_addr);
      end
      if (wr_req && !prev_req) begin
        cur_req = {wr_addr, wr_data};
        log_q.push_back(cur_req);
        rise_cyc.push_back(cyc);
        pending = 1;
        lat_cnt = LAT;
      end else if (pending) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          pending = 0;
          wr_done = 1;
          wr_nack = (resp_q.size() > 0) ? resp_q.pop_front() : 1'b0;
          done_cyc.push_back(cyc);
          checks++;
          if (!wr_req || {wr_addr, wr_data} !== cur_req) begin
            errors++;
            $display("FAIL req_stable: req=%0b word=%06h want 1/%06h", wr_req, {wr_addr, wr_data}, cur_req);
          end
        end
      end
      prev_req = wr_req;
    end
  end

  // Reference: walk the table by its rules and list the requests the SCCB side must see.
  logic [23:0] exp_q[$];
  bit          exp_err;
  int          exp_cnt;
  int          nack_plan [0:255];

  task automatic build_expected(input logic m);
    int base, len, k;
    logic [23:0] w;
    bit stop;
    exp_q.delete(); resp_q.delete();
    exp_err = 0; stop = 0;
    base = m ? M1_BASE : M0_BASE;
    len  = m ? M1_LEN : M0_LEN;
    exp_cnt = len;
    for (int i = 0; i < len && !stop; i++) begin
      w = rom[(base + i) % 256];
      if (w[23:8] == 16'hFFFE) begin
        exp_cnt = i + 1; stop = 1;
      end else if (w[23:8] != 16'hFFFF) begin
        k = nack_plan[i];
        for (int j = 0; j <= k && j <= MAX_RETRY; j++) begin
          exp_q.push_back(w);
          resp_q.push_back(j < k);
        end
        if (k > MAX_RETRY) begin exp_err = 1; stop = 1; end
      end
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 256; i++) nack_plan[i] = 0;
  endtask

  task automatic fill_rom_default();
    for (int i = 0; i < 256; i++) rom[i] = {16'h7000 + 16'(i), 8'(i)};
  endtask

  task automatic run_and_check(input string name, input logic m, input int mids);
    bit ok;
    log_q.delete(); rise_cyc.delete(); done_cyc.delete();
    addr_min = 1000; addr_max = -1;
    build_expected(m);
    @(negedge clk); mode = m; start = 1;
    @(negedge clk); start = 0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_start: done=%0b busy=%0b want 0/1", name, done, busy);
    end
    for (int s = 0; s < mids; s++) begin
      repeat (37) @(negedge clk);
      mode = ~m; start = 1;
      @(negedge clk); start = 0;
    end
    ok = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      if (done) ok = 1;
      else @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: done=%0b want 1", name, done); end
    checks++;
    if (log_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s_nreq: got %0d want %0d", name, log_q.size(), exp_q.size());
    end
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (log_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s_req%0d: got %06h want %06h", name, i, log_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < rise_cyc.size() && i <= done_cyc.size(); i++) begin
      checks++;
      if (rise_cyc[i] - done_cyc[i-1] < 2) begin
        errors++; $display("FAIL %s_req_gap%0d: got %0d want >=2", name, i, rise_cyc[i] - done_cyc[i-1]);
      end
    end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL %s_err: got %0b want %0b", name, err, exp_err); end
    if (!exp_err) begin
      checks++;
      if (entry_cnt !== 8'(exp_cnt)) begin
        errors++; $display("FAIL %s_cnt: got %0d want %0d", name, entry_cnt, exp_cnt);
      end
    end
    checks++;
    if (busy !== 1'b0 || wr_req !== 1'b0) begin
      errors++; $display("FAIL %s_idle: busy=%0b req=%0b want 0/0", name, busy, wr_req);
    end
  endtask

  task automatic test_reset();
    fill_rom_default(); clear_plan();
    reset = 1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_req, busy, done, err} !== 4'b0 || tbl_addr !== 8'd0 || entry_cnt !== 8'd0 ||
        wr_addr !== 16'd0 || wr_data !== 8'd0) begin
      errors++;
      $display("FAIL reset: req/busy/done/err=%b addr=%0d cnt=%0d wa=%h wd=%h want all 0",
               {wr_req, busy, done, err}, tbl_addr, entry_cnt, wr_addr, wr_data);
    end
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%0b done=%0b want 0/0", busy, done);
    end
  endtask

  task automatic test_basic();
    int gp, gr;
    fill_rom_default(); clear_plan();
    rom[0] = 24'h3103_11; rom[1] = 24'h3008_82; rom[2] = 24'h3008_42; rom[3] = 24'hFFFE_00;
    run_and_check("basic", 0, 0);
    if (rise_cyc.size() >= 3 && done_cyc.size() >= 2) begin
      gp = rise_cyc[1] - done_cyc[0];
      gr = rise_cyc[2] - done_cyc[1];
      checks++;
      if (gr - gp < RST_MS * TICK - 3 || gr - gp > RST_MS * TICK + 3) begin
        errors++; $display("FAIL basic_rst_wait: got %0d want %0d+-3", gr - gp, RST_MS * TICK);
      end
    end
  endtask

  task automatic test_delay_marker();
    int ga, gb, gc, gd;
    fill_rom_default(); clear_plan();
    rom[0] = 24'h1111_01; rom[1] = 24'hFFFF_02; rom[2] = 24'h2222_02; rom[3] = 24'hFFFF_00;
    rom[4] = 24'h3333_03; rom[5] = 24'h3008_42; rom[6] = 24'h4444_04; rom[7] = 24'hFFFE_00;
    run_and_check("delay", 0, 0);
    if (rise_cyc.size() >= 5 && done_cyc.size() >= 4) begin
      ga = rise_cyc[1] - done_cyc[0];
      gb = rise_cyc[2] - done_cyc[1];
      gc = rise_cyc[3] - done_cyc[2];
      gd = rise_cyc[4] - done_cyc[3];
      checks++;
      if (ga - gb < 2 * TICK - 3 || ga - gb > 2 * TICK + 3) begin
        errors++; $display("FAIL delay_2ms: got %0d want %0d+-3", ga - gb, 2 * TICK);
      end
      checks++;
      if (gb > gc + 3) begin errors++; $display("FAIL delay_0ms: got %0d want <=%0d", gb, gc + 3); end
      checks++;
      if (gc < 2 || gc > 6) begin errors++; $display("FAIL plain_gap: got %0d want 2..6", gc); end
      checks++;
      if (gd != gc) begin errors++; $display("FAIL no_rst_wait: got %0d want %0d", gd, gc); end
    end
  endtask

  task automatic test_nack();
    int n;
    fill_rom_default(); clear_plan();
    rom[0] = 24'h1000_AA; rom[1] = 24'h2000_BB; rom[2] = 24'hFFFE_00;
    nack_plan[1] = 2;
    run_and_check("nack2", 0, 0);
    nack_plan[1] = 4;
    run_and_check("nack4", 0, 0);
    n = log_q.size();
    repeat (100) @(negedge clk);
    checks++;
    if (log_q.size() != n || wr_req !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL nack4_quiet: nreq=%0d req=%0b done=%0b want %0d/0/1", log_q.size(), wr_req, done, n);
    end
  endtask

  task automatic test_mode1();
    fill_rom_default(); clear_plan();
    for (int i = 0; i < 10; i++) rom[200 + i] = {16'h4000 + 16'($urandom_range(0, 16'h0FFF)), 8'(i)};
    run_and_check("mode1", 1, 2);
    checks++;
    if (addr_min != 200 || addr_max != 209) begin
      errors++; $display("FAIL mode1_addr: got %0d..%0d want 200..209", addr_min, addr_max);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    fill_rom_default(); clear_plan();
    rom[0] = 24'h3103_11; rom[1] = 24'h5000_22; rom[2] = 24'hFFFE_00;
    @(negedge clk); mode = 0; start = 1;
    @(negedge clk); start = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (wr_req) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_req: req=%0b want 1", wr_req); end
    #2 reset = 1;
    #1;
    checks++;
    if (wr_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_drop: req=%0b busy=%0b done=%0b want 0/0/0", wr_req, busy, done);
    end
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    run_and_check("rerun", 0, 0);
  endtask

  task automatic test_random();
    int n, r, pos;
    logic m;
    for (int it = 0; it < 6; it++) begin
      fill_rom_default(); clear_plan();
      m = 1'($urandom_range(0, 1));
      n = m ? 10 : int'($urandom_range(3, 8));
      for (int i = 0; i < n; i++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      rom[(m ? M1_BASE : M0_BASE) + i] = {16'hFFFF, 8'($urandom_range(0, 2))};
        else if (r == 1) rom[(m ? M1_BASE : M0_BASE) + i] = {16'h3008, 8'($urandom_range(0, 255))};
        else             rom[(m ? M1_BASE : M0_BASE) + i] = {16'($urandom_range(0, 16'hFEFF)), 8'($urandom_range(0, 255))};
        r = int'($urandom_range(0, 11));
        nack_plan[i] = (r < 9) ? 0 : (r < 11) ? int'($urandom_range(1, 3)) : 4;
      end
      if (!m) rom[M0_BASE + n] = 24'hFFFE_00;
      else if ($urandom_range(0, 1) == 1) begin
        pos = int'($urandom_range(3, 9));
        rom[M1_BASE + pos] = 24'hFFFE_00;
      end
      run_and_check("random", m, 0);
    end
  endtask

  task automatic test_back_to_back();
    fill_rom_default(); clear_plan();
    rom[0] = 24'h1234_56; rom[1] = 24'h2345_67; rom[2] = 24'h3456_78; rom[3] = 24'hFFFE_00;
    nack_plan[2] = 1;
    run_and_check("b2b_a", 0, 0);
    run_and_check("b2b_b", 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_marker();
    test_nack();
    test_mode1();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
